// File: rtl/hack_pkg.sv
// Shared types and instruction field positions
// for the multi-cycle Hack CPU.
package hack_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_MEM_RD,
      S_EXEC,
      S_MEM_WR,
      S_HALT
   } state_t;

   localparam int A_BIT   = 12;
   localparam int CMP_LSB = 6;
   localparam int DEST_A  = 5;
   localparam int DEST_D  = 4;
   localparam int DEST_M  = 3;
   localparam int JLT     = 2;
   localparam int JEQ     = 1;
   localparam int JGT     = 0;

endpackage

// File: rtl/hack_alu_w.sv
// Width-parametrised Hack ALU.
// Purely combinational: X/Y preset, add/and, negate.
module hack_alu_w #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic [5:0]        ctl,
   output logic [DATA_W-1:0] out,
   output logic              zr,
   output logic              ng
);

   logic [DATA_W-1:0] xa;
   logic [DATA_W-1:0] ya;
   logic [DATA_W-1:0] s;

   // zx,nx,zy,ny,f,no applied in order
   always_comb begin
      xa = ctl[5] ? '0 : x;
      xa = ctl[4] ? ~xa : xa;
      ya = ctl[3] ? '0 : y;
      ya = ctl[2] ? ~ya : ya;
      s  = ctl[1] ? (xa + ya) : (xa & ya);
      out = ctl[0] ? ~s : s;
      zr = (out == '0);
      ng = out[DATA_W-1];
   end

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with handshaked instruction
// and data ports, halt detection and retire counter.
module hack_cpu_mc
   import hack_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 15,
   parameter int RESET_VECTOR = 0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              instr_req,
   output logic [ADDR_W-1:0] instr_addr,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] instr_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic              retire,
   output logic [31:0]       retired_cnt,
   output logic              halted
);

   state_t            state;
   state_t            state_n;
   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] d_q;
   logic [DATA_W-1:0] ir_q;
   logic [DATA_W-1:0] m_q;
   logic [DATA_W-1:0] r_q;
   logic              jmp_q;
   logic              halted_q;
   logic [31:0]       cnt_q;

   logic [DATA_W-1:0] y;
   logic [DATA_W-1:0] alu_out;
   logic              alu_zr;
   logic              alu_ng;
   logic              jcond;
   logic              is_c;
   logic [DATA_W-1:0] cval;
   logic              cjmp;
   logic              halt_hit;
   logic              commit;

   assign is_c = ir_q[DATA_W-1];
   assign y    = ir_q[A_BIT] ? m_q : a_q;

   hack_alu_w #(.DATA_W(DATA_W)) u_alu (
      .x   (d_q),
      .y   (y),
      .ctl (ir_q[CMP_LSB+5:CMP_LSB]),
      .out (alu_out),
      .zr  (alu_zr),
      .ng  (alu_ng)
   );

   assign jcond = (ir_q[JLT] & alu_ng)
                | (ir_q[JEQ] & alu_zr)
                | (ir_q[JGT] & ~alu_ng & ~alu_zr);

   assign instr_addr  = pc_q;
   assign mem_addr    = a_q[ADDR_W-1:0];
   assign mem_wdata   = r_q;
   assign pc          = pc_q;
   assign retire      = commit;
   assign retired_cnt = cnt_q;
   assign halted      = halted_q;

   // Commit value/jump: EXEC commits straight from the ALU,
   // MEM_WR from the latched result
   always_comb begin
      cval = r_q;
      cjmp = 1'b0;
      if (state == S_EXEC) begin
         cval = alu_out;
         cjmp = jcond;
      end else if (state == S_MEM_WR) begin
         cjmp = jmp_q;
      end
      halt_hit = cjmp && (a_q[ADDR_W-1:0] == pc_q);
   end

   // Next state and handshake outputs
   always_comb begin
      state_n   = state;
      instr_req = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      commit    = 1'b0;
      unique case (state)
         S_FETCH: begin
            instr_req = 1'b1;
            if (instr_valid) state_n = S_DECODE;
         end
         S_DECODE: begin
            if (!is_c) begin
               commit  = 1'b1;
               state_n = S_FETCH;
            end else if (ir_q[A_BIT]) begin
               state_n = S_MEM_RD;
            end else begin
               state_n = S_EXEC;
            end
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            if (mem_ready) state_n = S_EXEC;
         end
         S_EXEC: begin
            if (ir_q[DEST_M]) begin
               state_n = S_MEM_WR;
            end else begin
               commit  = 1'b1;
               state_n = halt_hit ? S_HALT : S_FETCH;
            end
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ready) begin
               commit  = 1'b1;
               state_n = halt_hit ? S_HALT : S_FETCH;
            end
         end
         S_HALT: state_n = S_HALT;
         default: state_n = S_FETCH;
      endcase
      if (!reset) begin
         instr_req = 1'b0;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         commit    = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_FETCH;
      else        state <= state_n;
   end

   // Datapath registers, commit, counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= ADDR_W'(RESET_VECTOR);
         a_q      <= '0;
         d_q      <= '0;
         ir_q     <= '0;
         m_q      <= '0;
         r_q      <= '0;
         jmp_q    <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (state == S_FETCH && instr_valid) ir_q <= instr_rdata;
         if (state == S_MEM_RD && mem_ready) m_q <= mem_rdata;
         if (state == S_EXEC) begin
            r_q   <= alu_out;
            jmp_q <= jcond;
         end
         if (commit) begin
            if (!is_c) begin
               a_q <= {1'b0, ir_q[DATA_W-2:0]};
            end else begin
               if (ir_q[DEST_D]) d_q <= cval;
               if (ir_q[DEST_A]) a_q <= cval;
            end
            pc_q  <= cjmp ? a_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
            cnt_q <= cnt_q + 32'd1;
            if (halt_hit) halted_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Scoreboard bench for hack_cpu_mc: retire and
// memory-write streams checked against queued expectations.
module tb_hack_cpu_mc;

   localparam logic [5:0] C_0   = 6'b101010;
   localparam logic [5:0] C_1   = 6'b111111;
   localparam logic [5:0] C_M1  = 6'b111010;
   localparam logic [5:0] C_D   = 6'b001100;
   localparam logic [5:0] C_A   = 6'b110000;
   localparam logic [5:0] C_DPA = 6'b000010;
   localparam logic [5:0] C_AP1 = 6'b110111;
   localparam logic [2:0] DN  = 3'b000;
   localparam logic [2:0] DM  = 3'b001;
   localparam logic [2:0] DD  = 3'b010;
   localparam logic [2:0] DAM = 3'b101;
   localparam logic [2:0] JN  = 3'b000;
   localparam logic [2:0] JQ  = 3'b010;
   localparam logic [2:0] JMP = 3'b111;

   typedef struct { int pc; int cyc; int idx; } ret_t;
   typedef struct { int addr; int data; } wr_t;

   logic        clk;
   logic        reset;
   logic        instr_req;
   logic [14:0] instr_addr;
   logic        instr_valid;
   logic [15:0] instr_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic [14:0] pc;
   logic        retire;
   logic [31:0] retired_cnt;
   logic        halted;

   logic [15:0] imem [0:32767];
   logic [15:0] dmem [0:32767];
   int iwait, dwait, iw_cnt, dw_cnt, dw_eff;
   int cyc, last_ret, ridx;
   int total, bad;
   ret_t exp_ret[$];
   wr_t  exp_wr[$];
   ret_t rr;
   wr_t  ww;
   logic ipend, dpend;
   logic [14:0] p_iaddr, p_daddr;
   logic [15:0] p_wdata;
   logic p_we;

   hack_cpu_mc dut (
      .clk(clk), .reset(reset),
      .instr_req(instr_req), .instr_addr(instr_addr),
      .instr_valid(instr_valid), .instr_rdata(instr_rdata),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .pc(pc), .retire(retire),
      .retired_cnt(retired_cnt), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dw_eff = (mem_addr == 15'd4 && !mem_we) ? 3 : dwait;
   assign instr_valid = instr_req && (iw_cnt >= iwait);
   assign mem_ready   = mem_req && (dw_cnt >= dw_eff);
   assign instr_rdata = imem[instr_addr];
   assign mem_rdata   = dmem[mem_addr];

   // wait-state counters of the memory models
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         iw_cnt <= 0;
         dw_cnt <= 0;
         cyc    <= 0;
      end else begin
         iw_cnt <= (instr_req && !instr_valid) ? iw_cnt + 1 : 0;
         dw_cnt <= (mem_req && !mem_ready) ? dw_cnt + 1 : 0;
         cyc    <= cyc + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s", nm);
   endtask

   // monitor: retire stream, write stream, handshake stability
   always @(negedge clk) begin
      if (!reset) begin
         last_ret = -1;
         ipend = 1'b0;
         dpend = 1'b0;
      end else begin
         if (retire) begin
            if (exp_ret.size() == 0) fail_now("unexpected_retire");
            else begin
               rr = exp_ret.pop_front();
               chk("retire_pc", 32'(pc), rr.pc);
               chk("retire_cnt", retired_cnt, rr.idx);
               chk("retire_cycles", cyc - last_ret, rr.cyc);
            end
            last_ret = cyc;
         end
         if (mem_req && mem_we && mem_ready) begin
            if (exp_wr.size() == 0) fail_now("unexpected_write");
            else begin
               ww = exp_wr.pop_front();
               chk("wr_addr", 32'(mem_addr), ww.addr);
               chk("wr_data", 32'(mem_wdata), ww.data);
            end
         end
         if (instr_req && ipend)
            chk("iaddr_stable", 32'(instr_addr), 32'(p_iaddr));
         if (mem_req && dpend) begin
            chk("daddr_stable", 32'(mem_addr), 32'(p_daddr));
            chk("dwe_stable", 32'(mem_we), 32'(p_we));
            chk("dwdata_stable", 32'(mem_wdata), 32'(p_wdata));
         end
         ipend   = instr_req && !instr_valid;
         dpend   = mem_req && !mem_ready;
         p_iaddr = instr_addr;
         p_daddr = mem_addr;
         p_we    = mem_we;
         p_wdata = mem_wdata;
      end
   end

   function automatic logic [15:0] ai(input int v);
      logic [31:0] t;
      t = v;
      return {1'b0, t[14:0]};
   endfunction

   function automatic logic [15:0] ci(input logic a,
      input logic [5:0] c, input logic [2:0] d, input logic [2:0] j);
      return {3'b111, a, c, d, j};
   endfunction

   task automatic er(input int p, input int c);
      ret_t t;
      t.pc = p;
      t.cyc = c;
      t.idx = ridx;
      ridx++;
      exp_ret.push_back(t);
   endtask

   task automatic ew(input int a, input int d);
      wr_t t;
      t.addr = a;
      t.data = d;
      exp_wr.push_back(t);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32768; i++) begin
         imem[i] = 16'h0;
         dmem[i] = 16'h0;
      end
      ridx = 0;
   endtask

   task automatic release_rst();
      @(negedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic assert_rst();
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
   endtask

   task automatic run_to_halt(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clk);
         if (halted) done = 1'b1;
      end
      #1;
      if (!done) fail_now("halt_timeout");
   endtask

   initial begin
      bit seen;
      total = 0;
      bad = 0;
      reset = 1'b0;
      iwait = 0;
      dwait = 0;
      clear_mem();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_pc", 32'(pc), 0);
      chk("rst_cnt", retired_cnt, 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_ireq", 32'(instr_req), 0);
      chk("rst_mreq", 32'(mem_req), 0);
      chk("rst_retire", 32'(retire), 0);

      // program 1: arithmetic, AM, branches, waited read, RMW
      imem[0]  = ai(5);
      imem[1]  = ci(0, C_A, DD, JN);
      imem[2]  = ai(7);
      imem[3]  = ci(0, C_DPA, DD, JN);
      imem[4]  = ai(0);
      imem[5]  = ci(0, C_D, DM, JN);
      imem[6]  = ai(3);
      imem[7]  = ci(0, C_M1, DAM, JN);
      imem[8]  = {3'b100, 1'b0, C_A, DD, JN};
      imem[9]  = ai(1);
      imem[10] = ci(0, C_D, DM, JN);
      imem[11] = ci(0, C_0, DD, JN);
      imem[12] = ai(16);
      imem[13] = ci(0, C_D, DN, JQ);
      imem[14] = ai(2);
      imem[15] = ci(0, C_1, DM, JN);
      imem[16] = ci(0, C_1, DD, JN);
      imem[17] = ai(30);
      imem[18] = ci(0, C_D, DN, JQ);
      imem[19] = ai(2);
      imem[20] = ci(0, C_D, DM, JN);
      imem[21] = ai(4);
      imem[22] = ci(1, C_AP1, DD, JN);
      imem[23] = ai(5);
      imem[24] = ci(0, C_D, DM, JN);
      imem[25] = ai(6);
      imem[26] = ci(1, C_AP1, DM, JN);
      imem[27] = ai(28);
      imem[28] = ci(0, C_0, DN, JMP);
      dmem[4] = 16'd41;
      dmem[6] = 16'd99;
      er(0, 2);  er(1, 3);  er(2, 2);  er(3, 3);
      er(4, 2);  er(5, 4);  er(6, 2);  er(7, 4);
      er(8, 3);  er(9, 2);  er(10, 4); er(11, 3);
      er(12, 2); er(13, 3); er(16, 3); er(17, 2);
      er(18, 3); er(19, 2); er(20, 4); er(21, 2);
      er(22, 7); er(23, 2); er(24, 4); er(25, 2);
      er(26, 5); er(27, 2); er(28, 3);
      ew(0, 12);
      ew(3, 16'hFFFF);
      ew(1, 16'hFFFF);
      ew(2, 1);
      ew(5, 42);
      ew(6, 100);
      release_rst();
      run_to_halt(400);
      chk("p1_pc", 32'(pc), 28);
      chk("p1_cnt", retired_cnt, 27);
      chk("p1_halted", 32'(halted), 1);
      assert_rst();
      chk("p1_rst_halted", 32'(halted), 0);

      // program 2: fetch waits, pc wrap, halt at pc 20
      clear_mem();
      iwait = 2;
      imem[0]     = ai(32767);
      imem[1]     = ci(0, C_D, DN, JQ);
      imem[32767] = ci(0, C_1, DD, JN);
      imem[2]     = ai(19);
      imem[3]     = ci(0, C_0, DN, JMP);
      imem[19]    = ai(20);
      imem[20]    = ci(0, C_0, DN, JMP);
      er(0, 4); er(1, 5); er(32767, 5); er(0, 4); er(1, 5);
      er(2, 4); er(3, 5); er(19, 4); er(20, 5);
      release_rst();
      run_to_halt(300);
      chk("p2_pc", 32'(pc), 20);
      chk("p2_cnt", retired_cnt, 9);
      repeat (10) begin
         @(negedge clk);
         chk("halt_no_ireq", 32'(instr_req), 0);
         chk("halt_no_mreq", 32'(mem_req), 0);
         chk("halt_cnt_frozen", retired_cnt, 9);
         chk("halt_sticky", 32'(halted), 1);
      end
      assert_rst();
      chk("p2_rst_halted", 32'(halted), 0);
      chk("p2_rst_pc", 32'(pc), 0);

      // program 3: reset while a write is stalled
      clear_mem();
      iwait = 0;
      dwait = 1000;
      imem[0] = ai(9);
      imem[1] = ci(0, C_A, DD, JN);
      imem[2] = ai(3);
      imem[3] = ci(0, C_D, DM, JN);
      imem[4] = ai(5);
      imem[5] = ci(0, C_0, DN, JMP);
      er(0, 2); er(1, 3); er(2, 2);
      release_rst();
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (mem_req && mem_we) seen = 1'b1;
      end
      if (!seen) fail_now("p3_wr_timeout");
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_mreq", 32'(mem_req), 0);
      chk("abort_mwe", 32'(mem_we), 0);
      chk("abort_ireq", 32'(instr_req), 0);
      chk("abort_pc", 32'(pc), 0);
      chk("abort_cnt", retired_cnt, 0);
      chk("abort_ret_q", exp_ret.size(), 0);
      dwait = 0;
      ridx = 0;
      er(0, 2); er(1, 3); er(2, 2); er(3, 4); er(4, 2); er(5, 3);
      ew(3, 9);
      release_rst();
      run_to_halt(200);
      chk("p3_pc", 32'(pc), 5);
      chk("p3_cnt", retired_cnt, 6);

      @(negedge clk);
      chk("left_retires", exp_ret.size(), 0);
      chk("left_writes", exp_wr.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hack_cpu_mc.md
# hack_cpu_mc

Parametrised multi-cycle successor to the single-cycle Hack CPU. It executes the Hack A/C instruction set at a configurable data width through separate instruction and data memory ports, each with a req/ready-style handshake, so it tolerates wait-stated memories. It also adds halt detection and a retired-instruction counter. The block sits between the instruction ROM/bus and the data RAM/bus in the Hack system top.

## Interface
- DATA_W, 16: data, A and D register width (≥ 16).
- ADDR_W, 15: PC and memory address width (≤ DATA_W-1).
- RESET_VECTOR, 0: PC value after reset.

- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_req  out  1  instruction fetch request.
- instr_addr  out  ADDR_W  fetch address, equal to pc.
- instr_valid  in  1  fetch data valid; completes the fetch.
- instr_rdata  in  DATA_W  fetched instruction.
- mem_req  out  1  data access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_W  data address, equal to A[ADDR_W-1:0].
- mem_wdata  out  DATA_W  write data.
- mem_ready  in  1  completes the data access.
- mem_rdata  in  DATA_W  read data, sampled when mem_ready is high.
- pc  out  ADDR_W  current program counter.
- retire  out  1  one-cycle pulse per committed instruction.
- retired_cnt  out  32  committed-instruction count; wraps.
- halted  out  1  sticky halt flag.

## Operation
- Instruction format:
  - bit DATA_W-1 = 0: A-instruction. A <= zero-extended IR[DATA_W-2:0].
  - bit DATA_W-1 = 1: C-instruction. Low 13 bits: [12] a (Y = M when 1, else A), [11:6] zx,nx,zy,ny,f,no, [5:3] dest A,D,M, [2:0] jump lt,eq,gt.
  - Bits DATA_W-2..13 are ignored.
- ALU: standard Hack semantics. X = D. ng = R[DATA_W-1]; zr = (R == 0).
- Jump condition: (j2 & ng) | (j1 & zr) | (j0 & ~ng & ~zr).
- FSM states:
  - FETCH: instr_req = 1. On instr_valid, IR <= instr_rdata, go to DECODE.
  - DECODE: for an A-instruction, commit and go to FETCH. For a C-instruction with a = 1, go to MEM_RD. Otherwise go to EXEC.
  - MEM_RD: mem_req = 1, mem_we = 0. On mem_ready, Mreg <= mem_rdata, go to EXEC.
  - EXEC: R <= ALU output; latch the jump decision. If dest M, go to MEM_WR. Otherwise commit and go to FETCH.
  - MEM_WR: mem_req = 1, mem_we = 1, mem_wdata = R. On mem_ready, commit and go to FETCH.
  - HALT: no requests issued; remain here until reset.
- Commit, in a single cycle:
  - D <= R if dest D; A <= R if dest A.
  - pc <= jump ? A_old[ADDR_W-1:0] : pc + 1. The increment wraps modulo 2^ADDR_W.
  - retire = 1; retired_cnt increments.
- Memory address and jump target always use A as it was before the committing instruction's update. This holds for dest AM and AMD.
- Halt: a taken jump whose target equals the current pc sets halted. The instruction still retires, and the next state is HALT.
- Handshakes:
  - req, addr, we and wdata stay stable until completion.
  - instr_valid or mem_ready arriving while no request is pending is ignored.
  - Unbounded wait is legal; there is no timeout.

## Timing
- Reset asserted, all values asynchronous:
  - pc = RESET_VECTOR; A = D = IR = Mreg = R = 0.
  - retired_cnt = 0; halted = 0; state = FETCH.
  - instr_req, mem_req, mem_we and retire are forced to 0 while reset is low.
- The first instr_req is high in the first cycle after reset deasserts.
- Minimum cycles per instruction, with zero wait states (valid/ready high on the first request cycle):
  - A-instruction: 2.
  - C-instruction, no M: 3.
  - C-instruction, M read only: 4.
  - C-instruction, M write only: 4.
  - C-instruction, M read and write: 5.
- Each wait-state cycle adds exactly one cycle.
- Reset mid-transaction abandons the request immediately; no commit occurs.
- Commit and the retire pulse occur in the same edge/cycle. The new pc is visible on instr_addr in the following FETCH.

## Structure
- Shared package hack_pkg:
  - state enum;
  - IR field bit positions (A_BIT = 12, CMP_LSB = 6, DEST_A/D/M = 5/4/3, JLT/JEQ/JGT = 2/1/0).
- Sub-module hack_alu_w #(DATA_W): combinational ALU with outputs out, zr and ng.
- Everything else (FSM, registers, counters) lives in hack_cpu_mc.

## Test plan
- @5, D=A, @7, D=D+A, @0, M=D (zero wait) -> write of addr 0, data 12. D = 12. retired_cnt = 6. The M=D instruction takes 4 cycles.
- @3, AM=-1 -> write at address 3 (old A), data 0xFFFF. A = 0xFFFF afterwards.
- D=0 then @10, D;JEQ -> pc = 10. D=1 then the same D;JEQ -> pc = old pc + 1.
- Data memory with mem_ready delayed 3 cycles on D=M+1 where M[4] = 41 -> D = 42. mem_req and mem_addr stay stable for all 4 request cycles. Total 7 cycles.
- At pc 20: @20, 0;JMP -> halted = 1, retired_cnt frozen, no further instr_req. Reset clears the halt.
- Reset asserted during MEM_WR with mem_ready low -> mem_req drops asynchronously. No D/A/pc change is committed. Fetch restarts at RESET_VECTOR.
